// File: rtl/ascii_convert_arbiter_pkg.sv
// ascii_convert_arbiter_pkg
//   Shared definitions for the ASCII converter arbiter: FSM state encoding,
//   the ASCII code of '0', and a width helper used for index/position ports.
//   No ports (package).
package ascii_convert_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Bits needed to index 'value' items; never returns less than 1 so that
  // single-bit indices still get a real port.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ascii_convert_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker: returns the first set request
//   at or after the pointer, wrapping around.
//   Ports:
//     req    in   NUM_REQ  request vector
//     ptr    in   IDX_W    round-robin start position (0..NUM_REQ-1)
//     any    out  1        at least one request set
//     onehot out  NUM_REQ  one-hot winner (0 when no request)
//     idx    out  IDX_W    winner index (0 when no request)
module rr_arbiter
  import ascii_convert_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = 0;
    // Scan from the pointer; the first hit locks out later candidates.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ascii_convert_arbiter.sv
// ascii_convert_arbiter
//   Shares one sequential binary-to-decimal converter between NUM_REQ
//   requesters. A round-robin winner's number is captured, converted one
//   digit per clock (LSD first), then streamed MSD-first as ASCII chars over
//   a valid/ready handshake.
//   Ports:
//     clk, rst    clock / asynchronous active-high reset
//     req         level request per requester
//     req_num     packed numbers, requester i at [i*NUM_W +: NUM_W]
//     grant       one-hot pulse, the cycle after a number is captured
//     busy        converter is converting or sending
//     char_valid  char_data/char_src/char_pos/char_last are valid
//     char_ready  consumer accepts the current char
//     char_data   ASCII digit '0'..'9'
//     char_src    requester owning the current char
//     char_pos    digit weight (DIGITS-1 = MSD, 0 = LSD)
//     char_last   high on the LSD char
module ascii_convert_arbiter
  import ascii_convert_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int NUM_W   = 17,
  parameter  int DIGITS  = 6,
  localparam int SRC_W   = clog2(NUM_REQ),
  localparam int POS_W   = clog2(DIGITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*NUM_W-1:0] req_num,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     char_valid,
  input  logic                     char_ready,
  output logic [7:0]               char_data,
  output logic [SRC_W-1:0]         char_src,
  output logic [POS_W-1:0]         char_pos,
  output logic                     char_last
);

  localparam logic [NUM_W-1:0] TEN      = NUM_W'(10);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DIGITS - 1);

  state_t             state_reg, state_next;
  logic [NUM_W-1:0]   work_reg;
  logic [POS_W-1:0]   cnt_reg;
  logic [POS_W-1:0]   pos_reg;
  logic [SRC_W-1:0]   owner_reg;
  logic [SRC_W-1:0]   rr_reg;
  logic [NUM_REQ-1:0] grant_reg;

  logic               win_any;
  logic [NUM_REQ-1:0] win_onehot;
  logic [SRC_W-1:0]   win_idx;

  logic [NUM_W-1:0]   req_num_arr [NUM_REQ];
  logic [3:0]         digbuf      [DIGITS];
  logic [3:0]         conv_digit;

  genvar gi;

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_num_arr[gi] = req_num[gi*NUM_W +: NUM_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (rr_reg),
    .any    (win_any),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  // Remainder always fits 4 bits; anything above 10^DIGITS simply never
  // gets a digit slot, which gives the mod-10^DIGITS reduction for free.
  assign conv_digit = 4'(work_reg % TEN);

  // Digit buffer: slot gi is written on the CONV cycle where cnt == gi.
  for (gi = 0; gi < DIGITS; gi++) begin : g_dig
    logic [3:0] digit_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        digit_reg <= '0;
      end else if (state_reg == CONV && cnt_reg == POS_W'(gi)) begin
        digit_reg <= conv_digit;
      end
    end
    assign digbuf[gi] = digit_reg;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_any) state_next = CONV;
      CONV:    if (cnt_reg == LAST_POS) state_next = SEND;
      SEND:    if (char_ready && pos_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, conversion and handshake bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg  <= '0;
      cnt_reg   <= '0;
      pos_reg   <= '0;
      owner_reg <= '0;
      rr_reg    <= '0;
      grant_reg <= '0;
    end else begin
      grant_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            work_reg  <= req_num_arr[win_idx];
            cnt_reg   <= '0;
            owner_reg <= win_idx;
            grant_reg <= win_onehot;
            rr_reg    <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        CONV: begin
          work_reg <= work_reg / TEN;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_POS) begin
            pos_reg <= LAST_POS;
          end
        end
        SEND: begin
          if (char_ready && pos_reg != '0) begin
            pos_reg <= pos_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs (char fields are forced to 0 outside SEND)
  always_comb begin
    busy       = (state_reg != IDLE);
    char_valid = 1'b0;
    char_data  = '0;
    char_src   = '0;
    char_pos   = '0;
    char_last  = 1'b0;
    if (state_reg == SEND) begin
      char_valid = 1'b1;
      char_data  = ASCII_ZERO + {4'h0, digbuf[pos_reg]};
      char_src   = owner_reg;
      char_pos   = pos_reg;
      char_last  = (pos_reg == '0);
    end
  end

  assign grant = grant_reg;

endmodule

// File: tb/tb_ascii_convert_arbiter.sv
`timescale 1ns/1ps
module tb_ascii_convert_arbiter;

  localparam int NUM_REQ = 2;
  localparam int NUM_W   = 17;
  localparam int DIGITS  = 6;
  localparam int SRC_W   = 1;
  localparam int POS_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*NUM_W-1:0] req_num = '0;
  logic                     char_ready = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     char_valid;
  logic [7:0]               char_data;
  logic [SRC_W-1:0]         char_src;
  logic [POS_W-1:0]         char_pos;
  logic                     char_last;

  ascii_convert_arbiter #(
    .NUM_REQ (NUM_REQ),
    .NUM_W   (NUM_W),
    .DIGITS  (DIGITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_num    (req_num),
    .grant      (grant),
    .busy       (busy),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_src   (char_src),
    .char_pos   (char_pos),
    .char_last  (char_last)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // Transaction-level reference: a job is a queue of expected decimal digits
  // (MSD first) preceded by DIGITS conversion cycles.
  int                 m_mode = 0;      // 0 idle, 1 converting, 2 sending
  int                 m_conv_left = 0;
  int                 m_src = 0;
  int                 m_rr = 0;
  logic [NUM_REQ-1:0] m_grant = '0;
  byte                m_q[$];

  // Chars the DUT actually handed over, with their owner.
  byte  got[$];
  int   got_src[$];
  logic prev_valid = 1'b0;
  logic [7:0] prev_data = '0;
  int   prev_src = 0;

  function automatic void load_digits(input int num);
    int p;
    m_q.delete();
    for (int d = DIGITS - 1; d >= 0; d--) begin
      p = 1;
      for (int j = 0; j < d; j++) p = p * 10;
      m_q.push_back(byte'((num / p) % 10));
    end
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_str(input string name, input int start, input string exp);
    string s;
    logic  ok;
    s  = "";
    ok = (got.size() >= start + exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (start + i < got.size()) begin
        s = $sformatf("%s%c", s, got[start+i]);
        if (got[start+i] != exp[i]) ok = 1'b0;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, s, exp);
    end else begin
      $display("%s: \"%s\" ok", name, s);
    end
  endtask

  // Model + per-cycle compare
  initial begin : model
    int w;
    int c;
    int num;
    logic [16:0] act_v;
    logic [16:0] exp_v;
    logic        e_valid;
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) begin
        m_mode     = 0;
        m_q.delete();
        m_grant    = '0;
        m_rr       = 0;
        m_src      = 0;
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && char_ready) begin
          got.push_back(byte'(prev_data));
          got_src.push_back(prev_src);
        end
        m_grant = '0;
        case (m_mode)
          0: begin
            if (req != '0) begin
              w = -1;
              for (int k = 0; k < NUM_REQ; k++) begin
                c = (m_rr + k) % NUM_REQ;
                if (w < 0 && req[c]) w = c;
              end
              num = int'(req_num[w*NUM_W +: NUM_W]);
              load_digits(num);
              m_src       = w;
              m_rr        = (w + 1) % NUM_REQ;
              m_grant     = NUM_REQ'(1 << w);
              m_mode      = 1;
              m_conv_left = DIGITS;
            end
          end
          1: begin
            m_conv_left--;
            if (m_conv_left == 0) m_mode = 2;
          end
          default: begin
            if (char_ready) begin
              void'(m_q.pop_front());
              if (m_q.size() == 0) m_mode = 0;
            end
          end
        endcase
      end
      #1;
      e_valid = (m_mode == 2);
      exp_v = {m_grant, 1'(m_mode != 0), e_valid,
               e_valid ? 8'h30 + 8'(m_q[0]) : 8'h00,
               e_valid ? SRC_W'(m_src) : SRC_W'(0),
               e_valid ? POS_W'(m_q.size() - 1) : POS_W'(0),
               1'(e_valid && m_q.size() == 1)};
      act_v = {grant, busy, char_valid, char_data, char_src, char_pos, char_last};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle %0d outputs {grant,busy,valid,data,src,pos,last}: got %h want %h",
                 cycle, act_v, exp_v);
      end
      prev_valid = char_valid;
      prev_data  = char_data;
      prev_src   = int'(char_src);
    end
  end

  task automatic wait_grant(input int src);
    int n;
    n = 0;
    while (grant[src] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_lit($sformatf("grant_seen_src%0d", src), int'(grant[src]), 1);
  endtask

  task automatic wait_chars(input int count, output int n);
    n = 0;
    while (got.size() < count && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (got.size() < count) check_lit("char_count_timeout", got.size(), count);
  endtask

  task automatic run_job(input int src, input int num, input int num_after,
                         input string exp_s, input string name);
    int n;
    got.delete();
    got_src.delete();
    char_ready = 1'b1;
    req_num[src*NUM_W +: NUM_W] = NUM_W'(num);
    req[src] = 1'b1;
    wait_grant(src);
    req = '0;
    req_num[src*NUM_W +: NUM_W] = NUM_W'(num_after);
    wait_chars(DIGITS, n);
    check_str(name, 0, exp_s);
    check_lit({name, "_job_cycles"}, n, 2 * DIGITS);
    if (got_src.size() > 0) check_lit({name, "_src"}, got_src[0], src);
  endtask

  initial begin : stim
    int n;
    @(negedge clk);
    @(negedge clk);
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_outputs", int'({grant, char_valid, char_data, char_pos, char_last}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_job(0, 12345,   12345, "012345", "single");
    run_job(0, 'h1FFFF, 0,     "131071", "max");
    run_job(0, 0,       0,     "000000", "zero");
    run_job(1, 100,     999,   "000100", "capture_iso");

    // Backpressure on the third char of 98765
    got.delete();
    got_src.delete();
    req_num[0 +: NUM_W] = NUM_W'(98765);
    req = 2'b01;
    char_ready = 1'b1;
    wait_grant(0);
    req = '0;
    n = 0;
    while (!(char_valid && char_pos == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("bp_data", int'(char_data), 'h38);
      check_lit("bp_pos", int'(char_pos), 3);
    end
    char_ready = 1'b1;
    wait_chars(DIGITS, n);
    check_str("backpressure", 0, "098765");

    // Reset in the middle of SEND after two chars
    got.delete();
    got_src.delete();
    req_num[0 +: NUM_W] = NUM_W'(12345);
    req = 2'b01;
    wait_grant(0);
    req = '0;
    wait_chars(2, n);
    rst = 1'b1;
    #1;
    check_lit("rst_mid_send_outputs",
              int'({grant, busy, char_valid, char_data, char_pos, char_last, char_src}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin after reset: pointer restarted at 0
    got.delete();
    got_src.delete();
    req_num = {NUM_W'(42), NUM_W'(7)};
    req = 2'b11;
    wait_chars(3 * DIGITS + 1, n);
    req = '0;
    wait_chars(4 * DIGITS, n);
    check_str("rr_job0", 0, "000007");
    check_str("rr_job1", 6, "000042");
    check_str("rr_job2", 12, "000007");
    check_str("rr_job3", 18, "000042");
    for (int j = 0; j < 4; j++) begin
      if (got_src.size() > j * DIGITS)
        check_lit($sformatf("rr_src_job%0d", j), got_src[j*DIGITS], j % 2);
    end
    repeat (3) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = NUM_REQ'($urandom);
      if ($urandom_range(0, 3) == 0) req_num[0 +: NUM_W] = NUM_W'($urandom);
      if ($urandom_range(0, 3) == 0) req_num[NUM_W +: NUM_W] = NUM_W'($urandom_range(0, 999));
      char_ready = ($urandom_range(0, 3) != 0);
    end
    req = '0;
    char_ready = 1'b1;
    repeat (40) @(negedge clk);
    check_lit("drain_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
